// File: rtl/gray_pkg.sv
// Shared Gray-code helpers and the default word width for the Gray stream decoder.
package gray_pkg;

  localparam int GRAY_WIDTH = 4;

  // Works for any narrower word that has been zero-extended, because leading zeros decode to zero.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic int unsigned popcount(input logic [31:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < 32; i++) begin
      n += 32'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/g2b_converter.sv
// Combinational Gray-to-binary converter. This is the inverse of b2g_converter.
module g2b_converter #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] in_gray,
  output logic [WIDTH-1:0] out_bin
);

  assign out_bin[WIDTH-1] = in_gray[WIDTH-1];

  // Each binary bit is the XOR of all Gray bits at or above its position.
  for (genvar gi = WIDTH - 2; gi >= 0; gi--) begin : g_bit
    assign out_bin[gi] = out_bin[gi+1] ^ in_gray[gi];
  end

endmodule

// File: rtl/gray_stream_decoder.sv
// Gray stream decoder with a valid/ready handshake, a single-bit-step check and a 1-cycle output register.
// Define GRAY_ERR_COUNT_EN to get the saturating err_count port.
module gray_stream_decoder
  import gray_pkg::*;
#(
  parameter int WIDTH     = GRAY_WIDTH,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_gray,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_bin,
  output logic                 out_step_err,
  output logic                 out_first
`ifdef GRAY_ERR_COUNT_EN
  ,
  output logic [ERR_CNT_W-1:0] err_count
`endif
);

  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_bin;
  logic             r_out_step_err;
  logic             r_out_first;
  logic [WIDTH-1:0] r_prev_gray;
  logic             r_have_prev;

  logic [WIDTH-1:0] w_bin;
  logic             w_accept;
  logic             w_have_prev_eff;
  logic             w_step_err;
  logic [31:0]      w_diff;

  g2b_converter #(.WIDTH(WIDTH)) u_g2b (
    .in_gray (in_gray),
    .out_bin (w_bin)
  );

  assign in_ready        = !r_out_valid || out_ready;
  assign w_accept        = in_valid && in_ready;
  // A clear arriving together with a word makes that word the first of a new history.
  assign w_have_prev_eff = r_have_prev && !clear;
  assign w_diff          = 32'(in_gray ^ r_prev_gray);
  assign w_step_err      = w_have_prev_eff && (popcount(w_diff) != 32'd1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid    <= 1'b0;
      r_out_bin      <= '0;
      r_out_step_err <= 1'b0;
      r_out_first    <= 1'b0;
      r_prev_gray    <= '0;
      r_have_prev    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_out_valid    <= 1'b1;
        r_out_bin      <= w_bin;
        r_out_step_err <= w_step_err;
        r_out_first    <= !w_have_prev_eff;
        r_prev_gray    <= in_gray;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
      if (w_accept) begin
        r_have_prev <= 1'b1;
      end else if (clear) begin
        r_have_prev <= 1'b0;
      end
    end
  end

`ifdef GRAY_ERR_COUNT_EN
  logic [ERR_CNT_W-1:0] r_err_count;

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      r_err_count <= '0;
    end else if (w_accept && w_step_err && !(&r_err_count)) begin
      r_err_count <= r_err_count + ERR_CNT_W'(1);
    end
  end

  assign err_count = r_err_count;
`endif

  assign out_valid    = r_out_valid;
  assign out_bin      = r_out_bin;
  assign out_step_err = r_out_step_err;
  assign out_first    = r_out_first;

endmodule

// File: tb/tb_gray_stream_decoder.sv
// Randomised scoreboard bench for gray_stream_decoder with WIDTH=4 and ERR_CNT_W=8.
// It also checks err_count when GRAY_ERR_COUNT_EN is defined.
module tb_gray_stream_decoder;

  typedef struct packed {
    logic [3:0] bin;
    logic       err;
    logic       first;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n, clear, in_valid, in_ready, out_valid, out_ready;
  logic       out_step_err, out_first;
  logic [3:0] in_gray, out_bin;
`ifdef GRAY_ERR_COUNT_EN
  logic [7:0] err_count;
`endif

  gray_stream_decoder #(.WIDTH(4), .ERR_CNT_W(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (clear),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_gray      (in_gray),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_bin      (out_bin),
    .out_step_err (out_step_err),
    .out_first    (out_first)
`ifdef GRAY_ERR_COUNT_EN
    ,
    .err_count    (err_count)
`endif
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t sb[$];

  logic       m_valid = 1'b0;
  logic       m_have  = 1'b0;
  logic [3:0] m_prev  = 4'b0;
  int         m_cnt   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Binary bit i is the parity of Gray bits i and above.
  function automatic logic [3:0] ref_bin(input logic [3:0] g);
    logic [3:0] b;
    for (int i = 0; i < 4; i++) b[i] = ^(g >> i);
    return b;
  endfunction

  task automatic drive(input logic v, input logic [3:0] g, input logic clr, input logic rdy);
    logic exp_ready, acc, eff, exp_err;
    @(negedge clk);
    in_valid = v; in_gray = g; clear = clr; out_ready = rdy;
    #1;
    exp_ready = !m_valid || rdy;
    check("in_ready", int'(in_ready), int'(exp_ready));
    check("out_valid", int'(out_valid), int'(m_valid));
`ifdef GRAY_ERR_COUNT_EN
    check("err_count", int'(err_count), m_cnt);
`endif
    acc = v && exp_ready;
    eff = m_have && !clr;
    exp_err = eff && ($countones(g ^ m_prev) != 1);
    if (acc) begin
      sb.push_back('{bin: ref_bin(g), err: exp_err, first: !eff});
      m_prev = g;
      m_have = 1'b1;
    end else if (clr) begin
      m_have = 1'b0;
    end
    if (clr) m_cnt = 0;
    else if (acc && exp_err && m_cnt < 255) m_cnt++;
    m_valid = acc ? 1'b1 : (rdy ? 1'b0 : m_valid);
  endtask

  // Monitor: every output transfer pops one expected word from the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    #1;
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_word", int'(out_bin), -1);
      end else begin
        e = sb.pop_front();
        $display("xfer bin=%0d err=%0d first=%0d", out_bin, out_step_err, out_first);
        check("out_bin", int'(out_bin), int'(e.bin));
        check("out_step_err", int'(out_step_err), int'(e.err));
        check("out_first", int'(out_first), int'(e.first));
      end
    end
  end

  initial begin
    logic [3:0] g;
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b1; in_gray = 4'b0101; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_bin", int'(out_bin), 0);
    check("rst_step_err", int'(out_step_err), 0);
    check("rst_first", int'(out_first), 0);
`ifdef GRAY_ERR_COUNT_EN
    check("rst_err_count", int'(err_count), 0);
`endif
    rst_n = 1'b1; in_valid = 1'b0;
    #1;
    check("post_rst_in_ready", int'(in_ready), 1);

    // In-order stream, then a legal step, a jump and a repeat.
    foreach (g_list[i]) drive(1'b1, g_list[i], 1'b0, 1'b1);
    // Back-pressure while the input toggles, then release.
    drive(1'b1, 4'b0111, 1'b0, 1'b0);
    drive(1'b1, 4'b1010, 1'b0, 1'b0);
    drive(1'b1, 4'b0111, 1'b0, 1'b0);
    drive(1'b1, 4'b0100, 1'b0, 1'b1);
    // The wrap from 1000 to 0000 is a legal single-bit step.
    drive(1'b1, 4'b1100, 1'b0, 1'b1);
    drive(1'b1, 4'b1000, 1'b0, 1'b1);
    drive(1'b1, 4'b0000, 1'b0, 1'b1);
    // A clear together with an accept restarts the history.
    drive(1'b1, 4'b1111, 1'b1, 1'b1);
    // Repeated words are step errors, so the counter saturates.
    for (int i = 0; i < 257; i++) drive(1'b1, 4'b1111, 1'b0, 1'b1);
    drive(1'b0, 4'b0000, 1'b0, 1'b1);

    // Random phase: mostly single-bit steps, with some jumps, stalls and clears.
    g = m_prev;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) != 0) g = m_prev ^ (4'b1 << $urandom_range(0, 3));
      else g = 4'($urandom_range(0, 15));
      drive(1'($urandom_range(0, 3) != 0), g, 1'($urandom_range(0, 15) == 0),
            1'($urandom_range(0, 2) != 0));
    end

    repeat (3) drive(1'b0, 4'b0000, 1'b0, 1'b1);
    check("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  logic [3:0] g_list [0:7] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010,
                               4'b0110, 4'b0010, 4'b0101, 4'b0101};

endmodule
